// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline types: FSM state encoding, register-file constants, flush levels.
package pipe_pkg;
   localparam int REG_AW   = 3;
   localparam int REG_ZERO = 0;

   // Flush lines are active-low.
   localparam logic FLUSH_ASSERT   = 1'b0;
   localparam logic FLUSH_DEASSERT = 1'b1;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      REDIR    = 2'd2
   } state_e;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX hazard inputs in, pipeline enables/flushes and counters out.
// master = pipeline datapath side, slave = hazard controller.
interface pipe_hazard_ctrl_if #(
   parameter int REG_AW = pipe_pkg::REG_AW,
   parameter int CNT_W  = 16
);
   logic [REG_AW-1:0] IFID_RSaddr_i;
   logic [REG_AW-1:0] IFID_RTaddr_i;
   logic              IFID_UsesRT_i;
   logic              IDEX_MemRead_i;
   logic [REG_AW-1:0] IDEX_RTaddr_i;
   logic              EX_Redirect_i;
   logic              cnt_clr_i;
   logic              PCWrite_o;
   logic              IFIDWrite_o;
   logic              IDEXWrite_o;
   logic              IFIDFlush_o;
   logic              IDEXFlush_o;
   logic [CNT_W-1:0]  stall_cnt_o;
   logic [CNT_W-1:0]  flush_cnt_o;
   logic [1:0]        state_o;

   modport master (
      output IFID_RSaddr_i, IFID_RTaddr_i, IFID_UsesRT_i, IDEX_MemRead_i,
             IDEX_RTaddr_i, EX_Redirect_i, cnt_clr_i,
      input  PCWrite_o, IFIDWrite_o, IDEXWrite_o, IFIDFlush_o, IDEXFlush_o,
             stall_cnt_o, flush_cnt_o, state_o
   );

   modport slave (
      input  IFID_RSaddr_i, IFID_RTaddr_i, IFID_UsesRT_i, IDEX_MemRead_i,
             IDEX_RTaddr_i, EX_Redirect_i, cnt_clr_i,
      output PCWrite_o, IFIDWrite_o, IDEXWrite_o, IFIDFlush_o, IDEXFlush_o,
             stall_cnt_o, flush_cnt_o, state_o
   );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter; clear beats increment, value holds at all-ones.
// One cycle from inc/clr to q; no backpressure.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] q
);
   logic [CNT_W-1:0] q_q;
   logic [CNT_W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (inc && (q_q != {CNT_W{1'b1}})) begin
         q_d = q_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall / branch-redirect squash controller for the 5-stage pipeline.
// Controls are combinational from registered state (zero latency); stalls the front end itself.
module pipe_hazard_ctrl #(
   parameter int REG_AW = pipe_pkg::REG_AW,
   parameter int CNT_W  = 16
) (
   input  logic               clk_i,
   input  logic               rst_n,
   pipe_hazard_ctrl_if.slave  hz
);
   import pipe_pkg::*;

   state_e state_q;
   state_e state_d;
   logic   rs_hit;
   logic   rt_hit;
   logic   lu;
   logic   rd;
   logic   stall_inc;
   logic   flush_inc;

   // Register 0 is hardwired, so a load targeting it can never create a hazard.
   always_comb begin
      rs_hit = (hz.IDEX_RTaddr_i == hz.IFID_RSaddr_i);
      rt_hit = hz.IFID_UsesRT_i && (hz.IDEX_RTaddr_i == hz.IFID_RTaddr_i);
      lu     = hz.IDEX_MemRead_i && (hz.IDEX_RTaddr_i != REG_AW'(REG_ZERO)) && (rs_hit || rt_hit);
      rd     = hz.EX_Redirect_i && (state_q != REDIR);
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = RUN;
      case (state_q)
         RUN: begin
            if (rd) begin
               state_d = REDIR;
            end else if (lu) begin
               state_d = LU_STALL;
            end
         end
         LU_STALL: state_d = RUN;
         REDIR:    state_d = RUN;
         default:  state_d = RUN;
      endcase
   end

   // Redirect outranks load-use: the stalled instruction is on the wrong path anyway.
   always_comb begin
      hz.PCWrite_o   = 1'b1;
      hz.IFIDWrite_o = 1'b1;
      hz.IDEXWrite_o = 1'b1;
      hz.IFIDFlush_o = FLUSH_DEASSERT;
      hz.IDEXFlush_o = FLUSH_DEASSERT;
      stall_inc      = 1'b0;
      flush_inc      = 1'b0;
      if (!rst_n) begin
         hz.PCWrite_o   = 1'b0;
         hz.IFIDWrite_o = 1'b0;
         hz.IDEXWrite_o = 1'b0;
         hz.IFIDFlush_o = FLUSH_ASSERT;
         hz.IDEXFlush_o = FLUSH_ASSERT;
      end else if (state_q == RUN) begin
         if (rd) begin
            hz.IFIDFlush_o = FLUSH_ASSERT;
            hz.IDEXFlush_o = FLUSH_ASSERT;
            flush_inc      = 1'b1;
         end else if (lu) begin
            hz.PCWrite_o   = 1'b0;
            hz.IFIDWrite_o = 1'b0;
            hz.IDEXWrite_o = 1'b0;
            stall_inc      = 1'b1;
         end
      end
   end

   assign hz.state_o = state_q;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .clr   (hz.cnt_clr_i),
      .inc   (stall_inc),
      .q     (hz.stall_cnt_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .clr   (hz.cnt_clr_i),
      .inc   (flush_inc),
      .q     (hz.flush_cnt_o)
   );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a narrow-counter copy shares the stimulus to reach saturation quickly.
module tb_pipe_hazard_ctrl;
   logic clk_i;
   logic rst_n;
   int   errors;
   int   checks;
   logic [15:0] exp_stall;
   logic [15:0] exp_flush;
   logic [4:0]  ctl;

   pipe_hazard_ctrl_if #(.REG_AW(3), .CNT_W(16)) hz ();
   pipe_hazard_ctrl_if #(.REG_AW(3), .CNT_W(4))  hz4 ();

   pipe_hazard_ctrl #(.REG_AW(3), .CNT_W(16)) dut (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .hz    (hz.slave)
   );

   pipe_hazard_ctrl #(.REG_AW(3), .CNT_W(4)) dut4 (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .hz    (hz4.slave)
   );

   assign hz4.IFID_RSaddr_i  = hz.IFID_RSaddr_i;
   assign hz4.IFID_RTaddr_i  = hz.IFID_RTaddr_i;
   assign hz4.IFID_UsesRT_i  = hz.IFID_UsesRT_i;
   assign hz4.IDEX_MemRead_i = hz.IDEX_MemRead_i;
   assign hz4.IDEX_RTaddr_i  = hz.IDEX_RTaddr_i;
   assign hz4.EX_Redirect_i  = hz.EX_Redirect_i;
   assign hz4.cnt_clr_i      = hz.cnt_clr_i;

   assign ctl = {hz.PCWrite_o, hz.IFIDWrite_o, hz.IDEXWrite_o, hz.IFIDFlush_o, hz.IDEXFlush_o};

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, bench did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_in(input logic mr, input logic [2:0] ex_rt, input logic [2:0] rs,
                         input logic [2:0] rt, input logic uses, input logic redir);
      hz.IDEX_MemRead_i = mr;
      hz.IDEX_RTaddr_i  = ex_rt;
      hz.IFID_RSaddr_i  = rs;
      hz.IFID_RTaddr_i  = rt;
      hz.IFID_UsesRT_i  = uses;
      hz.EX_Redirect_i  = redir;
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      hz.cnt_clr_i = 1'b0;
      set_in(0, 0, 0, 0, 0, 0);
      #3;
      checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL rst_ctl: got %b exp %b", ctl, 5'b00000); end
      checks++; if (hz.state_o !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", hz.state_o); end
      checks++; if (hz.stall_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_stall: got %0d exp 0", hz.stall_cnt_o); end
      checks++; if (hz.flush_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_flush: got %0d exp 0", hz.flush_cnt_o); end
      @(negedge clk_i);
      rst_n = 1'b1;
      #1;
      checks++; if (ctl !== 5'b11111) begin errors++; $display("FAIL rel_ctl: got %b exp %b", ctl, 5'b11111); end
      tick();
      checks++; if (hz.state_o !== 2'd0) begin errors++; $display("FAIL rel_state: got %0d exp 0", hz.state_o); end
      checks++; if ({hz.stall_cnt_o, hz.flush_cnt_o} !== 32'd0) begin errors++; $display("FAIL rel_cnt: got %h exp 0", {hz.stall_cnt_o, hz.flush_cnt_o}); end
      exp_stall = 16'd0;
      exp_flush = 16'd0;
   endtask

   task automatic test_lu_rs();
      set_in(1, 3, 3, 0, 0, 0);
      #1;
      checks++; if (ctl !== 5'b00011) begin errors++; $display("FAIL lu_rs_ctl: got %b exp %b", ctl, 5'b00011); end
      tick();
      exp_stall = exp_stall + 16'd1;
      set_in(0, 0, 0, 0, 0, 0);
      #1;
      checks++; if (hz.state_o !== 2'd1) begin errors++; $display("FAIL lu_rs_state: got %0d exp 1", hz.state_o); end
      checks++; if (ctl !== 5'b11111) begin errors++; $display("FAIL lu_rs_stall_ctl: got %b exp %b", ctl, 5'b11111); end
      checks++; if (hz.stall_cnt_o !== exp_stall) begin errors++; $display("FAIL lu_rs_cnt: got %0d exp %0d", hz.stall_cnt_o, exp_stall); end
      tick();
      checks++; if (hz.state_o !== 2'd0) begin errors++; $display("FAIL lu_rs_back: got %0d exp 0", hz.state_o); end
   endtask

   task automatic test_rt_gating();
      set_in(1, 5, 1, 5, 0, 0);
      #1;
      checks++; if (ctl !== 5'b11111) begin errors++; $display("FAIL rt_nouse_ctl: got %b exp %b", ctl, 5'b11111); end
      tick();
      checks++; if (hz.state_o !== 2'd0) begin errors++; $display("FAIL rt_nouse_state: got %0d exp 0", hz.state_o); end
      set_in(1, 5, 1, 5, 1, 0);
      #1;
      checks++; if (ctl !== 5'b00011) begin errors++; $display("FAIL rt_use_ctl: got %b exp %b", ctl, 5'b00011); end
      tick();
      exp_stall = exp_stall + 16'd1;
      set_in(0, 0, 0, 0, 0, 0);
      #1;
      checks++; if (hz.state_o !== 2'd1) begin errors++; $display("FAIL rt_use_state: got %0d exp 1", hz.state_o); end
      checks++; if (hz.stall_cnt_o !== exp_stall) begin errors++; $display("FAIL rt_use_cnt: got %0d exp %0d", hz.stall_cnt_o, exp_stall); end
      tick();
      set_in(1, 0, 0, 0, 1, 0);
      #1;
      checks++; if (ctl !== 5'b11111) begin errors++; $display("FAIL zero_reg_ctl: got %b exp %b", ctl, 5'b11111); end
      tick();
      checks++; if (hz.state_o !== 2'd0) begin errors++; $display("FAIL zero_reg_state: got %0d exp 0", hz.state_o); end
      checks++; if (hz.stall_cnt_o !== exp_stall) begin errors++; $display("FAIL zero_reg_cnt: got %0d exp %0d", hz.stall_cnt_o, exp_stall); end
      set_in(0, 3, 3, 3, 1, 0);
      #1;
      checks++; if (ctl !== 5'b11111) begin errors++; $display("FAIL no_load_ctl: got %b exp %b", ctl, 5'b11111); end
      tick();
   endtask

   task automatic test_redirect();
      set_in(1, 3, 3, 0, 0, 1);
      #1;
      checks++; if (ctl !== 5'b11100) begin errors++; $display("FAIL redir_ctl: got %b exp %b", ctl, 5'b11100); end
      tick();
      exp_flush = exp_flush + 16'd1;
      #1;
      checks++; if (hz.state_o !== 2'd2) begin errors++; $display("FAIL redir_state: got %0d exp 2", hz.state_o); end
      checks++; if (hz.flush_cnt_o !== exp_flush) begin errors++; $display("FAIL redir_fcnt: got %0d exp %0d", hz.flush_cnt_o, exp_flush); end
      checks++; if (hz.stall_cnt_o !== exp_stall) begin errors++; $display("FAIL redir_scnt: got %0d exp %0d", hz.stall_cnt_o, exp_stall); end
      checks++; if (ctl !== 5'b11111) begin errors++; $display("FAIL redir_held_ctl: got %b exp %b", ctl, 5'b11111); end
      tick();
      set_in(0, 0, 0, 0, 0, 0);
      #1;
      checks++; if (hz.state_o !== 2'd0) begin errors++; $display("FAIL redir_back: got %0d exp 0", hz.state_o); end
      checks++; if (hz.flush_cnt_o !== exp_flush) begin errors++; $display("FAIL redir_held_fcnt: got %0d exp %0d", hz.flush_cnt_o, exp_flush); end
      // A redirect seen while in LU_STALL must be dropped.
      set_in(1, 6, 6, 0, 0, 0);
      tick();
      exp_stall = exp_stall + 16'd1;
      set_in(0, 0, 0, 0, 0, 1);
      #1;
      checks++; if (ctl !== 5'b11111) begin errors++; $display("FAIL lus_redir_ctl: got %b exp %b", ctl, 5'b11111); end
      tick();
      set_in(0, 0, 0, 0, 0, 0);
      #1;
      checks++; if (hz.state_o !== 2'd0) begin errors++; $display("FAIL lus_redir_state: got %0d exp 0", hz.state_o); end
      checks++; if (hz.flush_cnt_o !== exp_flush) begin errors++; $display("FAIL lus_redir_fcnt: got %0d exp %0d", hz.flush_cnt_o, exp_flush); end
   endtask

   task automatic test_back_to_back();
      set_in(1, 2, 2, 0, 0, 0);
      #1;
      checks++; if (ctl !== 5'b00011) begin errors++; $display("FAIL b2b_first: got %b exp %b", ctl, 5'b00011); end
      tick();
      exp_stall = exp_stall + 16'd1;
      set_in(0, 0, 0, 0, 0, 0);
      #1;
      checks++; if (hz.state_o !== 2'd1) begin errors++; $display("FAIL b2b_state1: got %0d exp 1", hz.state_o); end
      tick();
      set_in(1, 4, 0, 4, 1, 0);
      #1;
      checks++; if (ctl !== 5'b00011) begin errors++; $display("FAIL b2b_second: got %b exp %b", ctl, 5'b00011); end
      tick();
      exp_stall = exp_stall + 16'd1;
      set_in(0, 0, 0, 0, 0, 0);
      #1;
      checks++; if (hz.state_o !== 2'd1) begin errors++; $display("FAIL b2b_state2: got %0d exp 1", hz.state_o); end
      checks++; if (hz.stall_cnt_o !== exp_stall) begin errors++; $display("FAIL b2b_cnt: got %0d exp %0d", hz.stall_cnt_o, exp_stall); end
      tick();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 20; i++) begin
         set_in(1, 7, 7, 0, 0, 0);
         tick();
         set_in(0, 0, 0, 0, 0, 0);
         tick();
      end
      exp_stall = exp_stall + 16'd20;
      checks++; if (hz.stall_cnt_o !== exp_stall) begin errors++; $display("FAIL sat_wide: got %0d exp %0d", hz.stall_cnt_o, exp_stall); end
      checks++; if (hz4.stall_cnt_o !== 4'hF) begin errors++; $display("FAIL sat_narrow: got %h exp f", hz4.stall_cnt_o); end
      set_in(1, 7, 7, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0);
      tick();
      checks++; if (hz4.stall_cnt_o !== 4'hF) begin errors++; $display("FAIL sat_hold: got %h exp f", hz4.stall_cnt_o); end
      hz.cnt_clr_i = 1'b1;
      set_in(1, 7, 7, 0, 0, 0);
      #1;
      checks++; if (ctl !== 5'b00011) begin errors++; $display("FAIL clr_stall_ctl: got %b exp %b", ctl, 5'b00011); end
      tick();
      hz.cnt_clr_i = 1'b0;
      set_in(0, 0, 0, 0, 0, 0);
      exp_stall = 16'd0;
      exp_flush = 16'd0;
      #1;
      checks++; if (hz.stall_cnt_o !== exp_stall) begin errors++; $display("FAIL clr_wide: got %0d exp 0", hz.stall_cnt_o); end
      checks++; if (hz4.stall_cnt_o !== 4'h0) begin errors++; $display("FAIL clr_narrow: got %h exp 0", hz4.stall_cnt_o); end
      checks++; if (hz.flush_cnt_o !== exp_flush) begin errors++; $display("FAIL clr_flush: got %0d exp 0", hz.flush_cnt_o); end
      checks++; if (hz.state_o !== 2'd1) begin errors++; $display("FAIL clr_state: got %0d exp 1", hz.state_o); end
      tick();
   endtask

   task automatic test_reset_mid();
      set_in(1, 1, 1, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0);
      #1;
      checks++; if (hz.state_o !== 2'd1) begin errors++; $display("FAIL mid_lu_pre: got %0d exp 1", hz.state_o); end
      rst_n = 1'b0;
      #1;
      checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL mid_lu_ctl: got %b exp %b", ctl, 5'b00000); end
      checks++; if (hz.state_o !== 2'd0) begin errors++; $display("FAIL mid_lu_state: got %0d exp 0", hz.state_o); end
      checks++; if (hz.stall_cnt_o !== 16'd0) begin errors++; $display("FAIL mid_lu_cnt: got %0d exp 0", hz.stall_cnt_o); end
      #1;
      rst_n = 1'b1;
      #1;
      checks++; if (ctl !== 5'b11111) begin errors++; $display("FAIL mid_lu_rel: got %b exp %b", ctl, 5'b11111); end
      tick();
      checks++; if (hz.state_o !== 2'd0) begin errors++; $display("FAIL mid_lu_after: got %0d exp 0", hz.state_o); end
      set_in(0, 0, 0, 0, 0, 1);
      tick();
      set_in(0, 0, 0, 0, 0, 0);
      #1;
      checks++; if (hz.state_o !== 2'd2) begin errors++; $display("FAIL mid_rd_pre: got %0d exp 2", hz.state_o); end
      rst_n = 1'b0;
      #1;
      checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL mid_rd_ctl: got %b exp %b", ctl, 5'b00000); end
      checks++; if (hz.state_o !== 2'd0) begin errors++; $display("FAIL mid_rd_state: got %0d exp 0", hz.state_o); end
      checks++; if (hz.flush_cnt_o !== 16'd0) begin errors++; $display("FAIL mid_rd_cnt: got %0d exp 0", hz.flush_cnt_o); end
      #1;
      rst_n = 1'b1;
      #1;
      checks++; if (ctl !== 5'b11111) begin errors++; $display("FAIL mid_rd_rel: got %b exp %b", ctl, 5'b11111); end
      tick();
      checks++; if (hz.state_o !== 2'd0) begin errors++; $display("FAIL mid_rd_after: got %0d exp 0", hz.state_o); end
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      exp_stall = 16'd0;
      exp_flush = 16'd0;
      test_reset();
      test_lu_rs();
      test_rt_gating();
      test_redirect();
      test_back_to_back();
      test_saturation();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
